// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The master side is the pipeline
// (it supplies hazard inputs); the slave side is hazard_ctrl (it returns controls and counters).
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic [2:0]       ID_ValidReg;
  logic [4:0]       EX_rd;
  logic [2:0]       EX_ValidReg;
  logic             EX_MemRead;
  logic             EX_redirect;
  logic             MEM_MemRead;
  logic             MEM_MemWrite;
  logic             dmem_ready;
  logic             cnt_clr;
  logic             stall_IF;
  logic             stall_ID;
  logic             stall_EX;
  logic             stall_MEM;
  logic             flush_ID;
  logic             flush_EX;
  logic             bubble_WB;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;
  logic [7:0]       wait_max;

  modport master (
    output ID_rs1, ID_rs2, ID_ValidReg, EX_rd, EX_ValidReg, EX_MemRead, EX_redirect,
           MEM_MemRead, MEM_MemWrite, dmem_ready, cnt_clr,
    input  stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, bubble_WB,
           mem_fault, stall_cycles, redirect_count, wait_max
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_ValidReg, EX_rd, EX_ValidReg, EX_MemRead, EX_redirect,
           MEM_MemRead, MEM_MemWrite, dmem_ready, cnt_clr,
    output stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, bubble_WB,
           mem_fault, stall_cycles, redirect_count, wait_max
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage RV32 pipeline: load-use, redirects, dmem waits.
// state    | meaning
// RUN      | normal issue; combinational hazards only
// MEM_WAIT | data-memory access outstanding, pipeline frozen
// FAULT    | dmem timeout, pipeline frozen until reset
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;
  localparam logic [7:0] TIMEOUT_TC  = 8'(MEM_TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       r_wait_max;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_redirect_count;

  logic w_mem_busy;
  logic w_load_use;
  logic w_fault;
  logic w_stall_all;
  logic w_redirect_acc;
  logic w_load_stall;
  logic w_wait_done;

  assign w_mem_busy = (hz.MEM_MemRead | hz.MEM_MemWrite) & ~hz.dmem_ready;
  assign w_load_use = hz.EX_MemRead & hz.EX_ValidReg[0] & (hz.EX_rd != 5'd0) &
                      ((hz.ID_ValidReg[1] & (hz.ID_rs1 == hz.EX_rd)) |
                       (hz.ID_ValidReg[2] & (hz.ID_rs2 == hz.EX_rd)));
  assign w_fault    = (r_state == ST_FAULT);

  // Priority: fault > memory wait > redirect > load-use; everything is quiet in reset.
  assign w_stall_all    = ~rst & (w_fault | w_mem_busy);
  assign w_redirect_acc = ~rst & ~w_fault & ~w_mem_busy & hz.EX_redirect;
  assign w_load_stall   = ~rst & ~w_fault & ~w_mem_busy & ~hz.EX_redirect & w_load_use;
  assign w_wait_done    = (r_state == ST_MEM_WAIT) & hz.dmem_ready;

  assign hz.stall_IF       = w_stall_all | w_load_stall;
  assign hz.stall_ID       = w_stall_all | w_load_stall;
  assign hz.stall_EX       = w_stall_all;
  assign hz.stall_MEM      = w_stall_all;
  assign hz.bubble_WB      = w_stall_all;
  assign hz.flush_ID       = w_redirect_acc;
  assign hz.flush_EX       = w_redirect_acc | w_load_stall;
  assign hz.mem_fault      = w_fault;
  assign hz.stall_cycles   = r_stall_cycles;
  assign hz.redirect_count = r_redirect_count;
  assign hz.wait_max       = r_wait_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_busy) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.dmem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == TIMEOUT_TC) begin
            r_state <= ST_FAULT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  // wait_cnt never exceeds 255, so max() alone keeps wait_max within 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles   <= '0;
      r_redirect_count <= '0;
      r_wait_max       <= 8'd0;
    end else if (hz.cnt_clr) begin
      r_stall_cycles   <= '0;
      r_redirect_count <= '0;
      r_wait_max       <= 8'd0;
    end else begin
      if (hz.stall_IF && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_redirect_acc && (r_redirect_count != '1))
        r_redirect_count <= r_redirect_count + CNT_W'(1);
      if (w_wait_done && (r_wait_cnt > r_wait_max))
        r_wait_max <= r_wait_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default build plus a CNT_W=4 build sharing the same stimulus.
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_LU   = 7'b1100010;
  localparam logic [6:0] CTL_RDR  = 7'b0000110;
  localparam logic [6:0] CTL_FRZ  = 7'b1111001;

  hazard_ctrl_if #(.CNT_W(32)) if_a ();
  hazard_ctrl_if #(.CNT_W(4))  if_b ();

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .hz(if_a.slave));
  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .hz(if_b.slave));

  assign if_b.ID_rs1       = if_a.ID_rs1;
  assign if_b.ID_rs2       = if_a.ID_rs2;
  assign if_b.ID_ValidReg  = if_a.ID_ValidReg;
  assign if_b.EX_rd        = if_a.EX_rd;
  assign if_b.EX_ValidReg  = if_a.EX_ValidReg;
  assign if_b.EX_MemRead   = if_a.EX_MemRead;
  assign if_b.EX_redirect  = if_a.EX_redirect;
  assign if_b.MEM_MemRead  = if_a.MEM_MemRead;
  assign if_b.MEM_MemWrite = if_a.MEM_MemWrite;
  assign if_b.dmem_ready   = if_a.dmem_ready;
  assign if_b.cnt_clr      = if_a.cnt_clr;

  logic [6:0] ctl_a;
  assign ctl_a = {if_a.stall_IF, if_a.stall_ID, if_a.stall_EX, if_a.stall_MEM,
                  if_a.flush_ID, if_a.flush_EX, if_a.bubble_WB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, ctl_a}, {25'd0, exp});
  endtask

  task automatic idle();
    if_a.ID_rs1 = 5'd0;  if_a.ID_rs2 = 5'd0;  if_a.ID_ValidReg = 3'b000;
    if_a.EX_rd = 5'd0;   if_a.EX_ValidReg = 3'b000;
    if_a.EX_MemRead = 1'b0;  if_a.EX_redirect = 1'b0;
    if_a.MEM_MemRead = 1'b0; if_a.MEM_MemWrite = 1'b0;
    if_a.dmem_ready = 1'b0;  if_a.cnt_clr = 1'b0;
  endtask

  task automatic load_use_x5();
    if_a.EX_MemRead = 1'b1; if_a.EX_rd = 5'd5; if_a.EX_ValidReg = 3'b001;
    if_a.ID_rs1 = 5'd5; if_a.ID_ValidReg = 3'b011;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b1;
    if_a.MEM_MemRead = 1'b1;
    #2;
    chk_ctl("reset_ctl_gated", CTL_NONE);
    chk("reset_fault", {31'd0, if_a.mem_fault}, 32'd0);
    chk("reset_stall_cnt", if_a.stall_cycles, 32'd0);
    chk("reset_wait_max", {24'd0, if_a.wait_max}, 32'd0);
    idle();
    cycle();
    rst = 1'b0;
    cycle();

    load_use_x5();
    #1 chk_ctl("lu_stall", CTL_LU);
    cycle();
    if_a.EX_MemRead = 1'b0; if_a.EX_ValidReg = 3'b000; if_a.EX_rd = 5'd0;
    #1 chk_ctl("lu_bubble_next", CTL_NONE);
    chk("lu_stall_cnt", if_a.stall_cycles, 32'd1);
    cycle();

    load_use_x5(); if_a.EX_rd = 5'd0; if_a.ID_rs1 = 5'd0;
    #1 chk_ctl("lu_rd_x0", CTL_NONE);
    cycle();
    load_use_x5(); if_a.ID_ValidReg = 3'b001;
    #1 chk_ctl("lu_rs1_invalid", CTL_NONE);
    cycle();
    load_use_x5(); if_a.ID_rs1 = 5'd7; if_a.ID_rs2 = 5'd5; if_a.ID_ValidReg = 3'b101;
    #1 chk_ctl("lu_rs2_match", CTL_LU);
    cycle();

    idle(); load_use_x5(); if_a.EX_redirect = 1'b1;
    #1 chk_ctl("lu_and_redirect", CTL_RDR);
    cycle();
    chk("redirect_cnt_1", if_a.redirect_count, 32'd1);
    chk("stall_cnt_2", if_a.stall_cycles, 32'd2);

    idle(); if_a.MEM_MemRead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctl("mem_wait_frz", CTL_FRZ);
      cycle();
    end
    if_a.dmem_ready = 1'b1;
    #1 chk_ctl("mem_ready_cycle", CTL_NONE);
    cycle();
    chk("wait_max_3", {24'd0, if_a.wait_max}, 32'd3);
    chk("stall_cnt_5", if_a.stall_cycles, 32'd5);

    idle(); if_a.MEM_MemRead = 1'b1; if_a.EX_redirect = 1'b1;
    #1 chk_ctl("redirect_in_busy", CTL_FRZ);
    cycle();
    if_a.dmem_ready = 1'b1;
    #1 chk_ctl("redirect_on_ready", CTL_RDR);
    cycle();
    chk("redirect_cnt_2", if_a.redirect_count, 32'd2);
    chk("stall_cnt_6", if_a.stall_cycles, 32'd6);
    chk("wait_max_keep", {24'd0, if_a.wait_max}, 32'd3);

    idle(); load_use_x5();
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_b_stall", {28'd0, if_b.stall_cycles}, 32'd15);
    chk("nosat_a_stall", if_a.stall_cycles, 32'd26);
    chk("b_redirect_2", {28'd0, if_b.redirect_count}, 32'd2);
    if_a.cnt_clr = 1'b1;
    cycle();
    chk("clr_b_stall", {28'd0, if_b.stall_cycles}, 32'd0);
    chk("clr_a_stall", if_a.stall_cycles, 32'd0);
    chk("clr_a_redirect", if_a.redirect_count, 32'd0);
    chk("clr_wait_max", {24'd0, if_a.wait_max}, 32'd0);

    idle(); if_a.MEM_MemWrite = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1 chk("pre_timeout_fault", {31'd0, if_a.mem_fault}, 32'd0);
      cycle();
    end
    chk("timeout_fault", {31'd0, if_a.mem_fault}, 32'd1);
    idle(); if_a.EX_redirect = 1'b1; if_a.dmem_ready = 1'b1;
    #1 chk_ctl("fault_frz", CTL_FRZ);
    cycle();
    chk("fault_stall_cnt", if_a.stall_cycles, 32'd17);
    chk("fault_no_redirect", if_a.redirect_count, 32'd0);
    chk("fault_sticky", {31'd0, if_a.mem_fault}, 32'd1);

    #2 rst = 1'b1;
    #1 chk_ctl("async_rst_ctl", CTL_NONE);
    chk("async_rst_fault", {31'd0, if_a.mem_fault}, 32'd0);
    chk("async_rst_cnt", if_a.stall_cycles, 32'd0);
    #1 rst = 1'b0;
    idle();
    cycle();
    chk("post_rst_fault", {31'd0, if_a.mem_fault}, 32'd0);
    load_use_x5();
    #1 chk_ctl("post_rst_run_lu", CTL_LU);
    cycle();
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
